// File: rtl/pair_pat_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pair_pat_pkg
// Description : Shared types and defaults for the pair pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package pair_pat_pkg;

    localparam int DEPTH_DEF  = 8;
    localparam int HOLD_W_DEF = 4;

    // One pattern entry: the two stimulus bits and how many extra cycles to hold them
    typedef struct packed {
        logic                  a;
        logic                  b;
        logic [HOLD_W_DEF-1:0] hold;
    } pair_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } pair_state_t;

    // Builds an entry in the {a, b, hold} packing used by wr_data
    function automatic pair_entry_t mk_entry(input logic a, input logic b,
                                             input logic [HOLD_W_DEF-1:0] hold);
        pair_entry_t e;
        e.a    = a;
        e.b    = b;
        e.hold = hold;
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pair_pat_mem.sv
`default_nettype none
// ============================================================================
// Module      : pair_pat_mem
// Description : Pattern entry storage, one synchronous write port and one
//               asynchronous read port. Contents are not touched by reset.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_pat_mem
    import pair_pat_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic                       clk,
    input  logic                       we,
    input  logic [$clog2(DEPTH)-1:0]   waddr,
    input  logic [HOLD_W+1:0]          wdata,
    input  logic [$clog2(DEPTH)-1:0]   raddr,
    output logic [HOLD_W+1:0]          rdata
);

    logic [HOLD_W+1:0] mem_q [DEPTH];

    // Write port: one entry per enabled clock
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Read port is combinational so a same-cycle write is not yet visible
    assign rdata = mem_q[raddr];

endmodule
`default_nettype wire

// File: rtl/pair_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : pair_pattern_gen
// Description : Plays a programmed list of (a, b, hold) entries onto two
//               stimulus bits, with the expected a&b alongside. Supports
//               one-shot and looping playback, abort and a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module pair_pattern_gen
    import pair_pat_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int HOLD_W = HOLD_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(DEPTH)-1:0]   wr_addr,
    input  logic [HOLD_W+1:0]          wr_data,
    input  logic [$clog2(DEPTH):0]     len,
    input  logic                       loop,
    input  logic                       start,
    input  logic                       abort,
    output logic                       a,
    output logic                       b,
    output logic                       exp_and,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH)-1:0]   step_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    pair_state_t        state_q, state_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               exp_and_q, exp_and_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AW-1:0]      step_idx_q, step_idx_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [LW-1:0]      len_q, len_d;
    logic               loop_q, loop_d;

    logic [AW-1:0]      w_rd_addr;
    logic [HOLD_W+1:0]  w_rd_data;
    logic               w_rd_a;
    logic               w_rd_b;
    logic [HOLD_W-1:0]  w_rd_hold;
    logic [LW-1:0]      w_start_len;
    logic [AW-1:0]      w_last_idx;
    logic               w_last;

    // Writes are only accepted while no playback is in progress
    pair_pat_mem #(
        .DEPTH  (DEPTH),
        .HOLD_W (HOLD_W)
    ) u_mem (
        .clk    (clk),
        .we     (wr_en && !busy_q),
        .waddr  (wr_addr),
        .wdata  (wr_data),
        .raddr  (w_rd_addr),
        .rdata  (w_rd_data)
    );

    assign w_rd_a    = w_rd_data[HOLD_W+1];
    assign w_rd_b    = w_rd_data[HOLD_W];
    assign w_rd_hold = w_rd_data[HOLD_W-1:0];

    // Requested lengths beyond the table size play the whole table
    assign w_start_len = (len > LW'(DEPTH)) ? LW'(DEPTH) : len;
    assign w_last_idx  = AW'(len_q - LW'(1));
    assign w_last      = (step_idx_q == w_last_idx);

    // Read address points at the entry the next advance will present
    always_comb begin
        w_rd_addr = '0;
        if (state_q == RUN && !w_last) begin
            w_rd_addr = step_idx_q + AW'(1);
        end
    end

    // Next-state and output computation; abort outranks advance and wrap
    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        step_idx_d = step_idx_q;
        hold_d     = hold_q;
        len_d      = len_q;
        loop_d     = loop_q;
        case (state_q)
            IDLE: begin
                a_d    = 1'b0;
                b_d    = 1'b0;
                busy_d = 1'b0;
                if (start && (len != '0)) begin
                    state_d    = RUN;
                    step_idx_d = '0;
                    a_d        = w_rd_a;
                    b_d        = w_rd_b;
                    hold_d     = w_rd_hold;
                    busy_d     = 1'b1;
                    len_d      = w_start_len;
                    loop_d     = loop;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d    = IDLE;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    busy_d     = 1'b0;
                    step_idx_d = '0;
                    hold_d     = '0;
                end else if (hold_q != '0) begin
                    hold_d = hold_q - HOLD_W'(1);
                end else if (!w_last || loop_q) begin
                    step_idx_d = w_last ? '0 : step_idx_q + AW'(1);
                    a_d        = w_rd_a;
                    b_d        = w_rd_b;
                    hold_d     = w_rd_hold;
                end else begin
                    state_d    = FIN;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                    step_idx_d = '0;
                end
            end
            FIN: begin
                state_d = IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d    = IDLE;
                a_d        = 1'b0;
                b_d        = 1'b0;
                busy_d     = 1'b0;
                step_idx_d = '0;
                hold_d     = '0;
            end
        endcase
        exp_and_d = a_d & b_d;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            a_q        <= 1'b0;
            b_q        <= 1'b0;
            exp_and_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            step_idx_q <= '0;
            hold_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            exp_and_q  <= exp_and_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            step_idx_q <= step_idx_d;
            hold_q     <= hold_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
        end
    end

    assign a        = a_q;
    assign b        = b_q;
    assign exp_and  = exp_and_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign step_idx = step_idx_q;

endmodule
`default_nettype wire

// File: doc/pair_pattern_gen.md
PAIR_PATTERN_GEN -- requirements
Module: pair_pattern_gen

Interface
REQ-001 Parameter DEPTH, default 8: number of pattern entries.
REQ-002 Parameter HOLD_W, default 4: width of the per-entry hold count.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset, with ports as follows:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- wr_en  input  1  write one pattern entry
- wr_addr  input  $clog2(DEPTH)  entry index
- wr_data  input  HOLD_W+2  {a, b, hold}; a is the MSB
- len  input  $clog2(DEPTH)+1  entries to play, sampled at start
- loop  input  1  repeat pattern, sampled at start
- start  input  1  begin playback (level; acted on only in IDLE)
- abort  input  1  stop playback
- a  output  1  driven stimulus bit
- b  output  1  driven stimulus bit
- exp_and  output  1  expected a&&b for the current a/b
- busy  output  1  playback active
- done  output  1  one-cycle completion pulse
- step_idx  output  $clog2(DEPTH)  entry currently driven

Function
REQ-004 All outputs SHALL be registered and change only on rising clk.
REQ-005 The FSM SHALL have the states IDLE, RUN and FIN.
REQ-006 In IDLE with start=1 and len!=0, the next edge SHALL enter RUN with step_idx=0, a/b set to entry 0, hold counter loaded with entry 0 hold, and busy=1.
REQ-007 start with len=0 SHALL be ignored: the FSM stays in IDLE and done stays 0.
REQ-008 If len>DEPTH, the played length SHALL be DEPTH.
REQ-009 Each entry SHALL drive a/b for exactly hold+1 cycles; hold=0 gives one cycle.
REQ-010 When an entry's hold expires and it is not the last entry, the next edge SHALL present entry step_idx+1 with no gap cycle.
REQ-011 When the last entry (len-1) expires:
- with loop=1, the FSM SHALL wrap to entry 0 with no gap cycle;
- with loop=0, the FSM SHALL enter FIN.
REQ-012 FIN SHALL last one cycle with done=1, busy=0 and a=b=0, then return to IDLE.
REQ-013 abort=1 in RUN SHALL return the FSM to IDLE at the next edge with a=b=0, busy=0 and done=0.
REQ-014 abort SHALL take priority over entry advance and wrap.
REQ-015 start asserted in RUN or FIN SHALL be ignored.
REQ-016 len and loop SHALL be latched at start; later changes SHALL have no effect on the current playback.
REQ-017 wr_en SHALL write the memory only while busy=0; writes while busy=1 SHALL be dropped.
REQ-018 A write and a start in the same IDLE cycle SHALL both take effect, with entry 0 read from the pre-write contents.
REQ-019 exp_and SHALL equal a&b in the same cycle, registered alongside a/b.
REQ-020 In IDLE, a=b=exp_and=0.

Reset
REQ-021 When rst=1 at a rising edge, the FSM SHALL enter IDLE, and a, b, exp_and, busy, done, step_idx and the hold counter SHALL be 0.
REQ-022 rst SHALL override start, abort and an in-progress RUN.
REQ-023 Memory contents SHALL NOT be cleared by rst.
REQ-024 The cycle after rst deasserts, start SHALL be honored normally.

Structure
REQ-025 A shared package pair_pat_pkg SHALL hold:
- DEPTH_DEF and HOLD_W_DEF;
- the packed entry struct {a, b, hold};
- the state enum {IDLE, RUN, FIN}.
REQ-026 The entry storage SHALL be a sub-module pair_pat_mem: DEPTH x (HOLD_W+2), one synchronous write port, one asynchronous read port.
REQ-027 The top level SHALL contain the FSM, the hold counter and the index counter.
REQ-028 The RTL SHALL be synthesizable, with no latches.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- Program entries {0,0,0},{1,0,0},{1,1,0},{0,1,0},{1,1,0}; len=5, loop=0, start -> over 5 cycles a=0,1,1,0,1, b=0,0,1,1,1, exp_and=0,0,1,0,1; then done=1 for one cycle; busy=0.
- Entry0={1,1,3}, len=1, loop=0 -> a=b=1 for exactly 4 cycles, then done.
- len=2 entries {1,0,0},{0,1,0}, loop=1 -> a/b alternate 10,01,10,01 for at least 6 cycles; abort -> next cycle a=b=0, busy=0, done never asserted.
- start with len=0 -> busy stays 0 and done stays 0; start while busy -> playback unchanged.
- wr_en to entry 0 during RUN -> memory unchanged, verified by replay.
- rst asserted mid-RUN -> next cycle all outputs 0 and FSM in IDLE; after reset, replay of the old pattern uses the retained memory.
REQ-030 An SVA checker SHALL assert exp_and == (a && b) on every posedge clk.
REQ-031 An SVA checker SHALL assert that done is a single-cycle pulse never coincident with busy.
